ula_scheduler: RTL and testbench
================================

# ula_scheduler

Sequencer and arbiter that shares one 8-bit ULA (AND/OR/ADD/SUB with overflow flag) between two requesters. Each requester presents operands and a 2-bit function code on a valid/ready port. The scheduler grants round-robin, drives the external ULA from registered operands, and captures the result and overflow flag. It returns them on a single tagged response port and keeps a saturating count of overflowing operations. It sits between the processor-side requesters and the combinational ULA.

## Interface

- WIDTH, 8, operand/result width; must equal the ULA width
- CNT_W, 8, width of the overflow counter

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  signed operands
- req0_f  in  2  function: 00 AND, 01 OR, 10 ADD, 11 SUB
- req1_valid, req1_ready, req1_a, req1_b, req1_f: same as requester 0, for requester 1
- alu_a, alu_b  out  WIDTH  operands to ULA
- alu_f  out  2  function to ULA
- alu_saida  in  WIDTH  ULA result
- alu_flag_o  in  1  ULA overflow flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_saida  out  WIDTH  captured result
- rsp_flag_o  out  1  captured overflow flag
- busy  out  1  high whenever state is not IDLE
- ovf_count  out  CNT_W  saturating count of results with flag set

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one requester. Assert its reqN_ready combinationally in the same cycle. Load alu_a/alu_b/alu_f and the id register, then go to EXEC.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted last (last_grant register).
  - last_grant resets to 1, so requester 0 wins the first tie.
  - reqN_ready is never high outside IDLE and never high for both requesters at once.
- EXEC: one cycle with alu_* held. At the end of the cycle:
  - capture alu_saida into rsp_saida
  - capture alu_flag_o into rsp_flag_o, forced to 0 when alu_f is 00 or 01
  - go to RESP
- ovf_count increments on the EXEC capture when the captured flag is 1. It saturates at 2^CNT_W-1 and never wraps.
- RESP: rsp_valid=1. rsp_id, rsp_saida and rsp_flag_o stay stable until rsp_valid&&rsp_ready is sampled. On that handshake return to IDLE and drop rsp_valid.
- alu_a/alu_b/alu_f are registers. They keep the last issued operation until the next grant.
- Requesters must hold operands stable while valid and not ready. The scheduler samples them only on the accepting edge.
- Asynchronous reset, any state (including mid-EXEC or mid-RESP):
  - state IDLE; the in-flight operation is discarded with no response
  - alu_a=0, alu_b=0, alu_f=00
  - rsp_valid=0, rsp_id=0, rsp_saida=0, rsp_flag_o=0
  - ovf_count=0, last_grant=1, busy=0
  - req0_ready/req1_ready are 0 while rst_n is low

## Timing

- Accept at edge E0 (reqN_valid&&reqN_ready).
- After E0: EXEC, and alu_* are valid for the whole cycle.
- Capture at E1. rsp_valid is high after E1, so latency from accept to rsp_valid is 2 cycles.
- Response handshake at edge Ek (k≥2), returning to IDLE. The earliest next accept is at Ek+1.
- Minimum 3 cycles per operation with rsp_ready tied high. There is no overlap between operations.
- ovf_count updates at E1 and is visible the same cycle rsp_valid rises.
- Simultaneous new request and pending response: the request waits (ready=0) until the FSM is back in IDLE.

## Test plan

- Requester 0 alone, A=100, B=50, F=10, rsp_ready=1:
  - req0_ready high in the accept cycle
  - rsp_valid 2 cycles later with rsp_id=0, rsp_saida=0x96 (-106), rsp_flag_o=1
  - ovf_count=1
- Both valid from reset; req0 (A=5, B=3, F=11), req1 (A=0xF0, B=0x3C, F=00):
  - requester 0 first: rsp_saida=2, flag 0
  - then id 1: rsp_saida=0x30, flag 0
  - req1_ready stays 0 until the first response completes
- Backpressure: rsp_ready low for 5 cycles during RESP → rsp_valid/rsp_id/rsp_saida/rsp_flag_o constant, both readys 0, busy=1. Handshake completes on the cycle rsp_ready rises, and busy falls next cycle.
- Fairness: both requesters held valid for 6 operations with rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1, one accept every 3 cycles.
- Saturation: 260 operations of A=127, B=1, F=10 → each rsp_saida=0x80, flag 1, ovf_count reaches 255 and stays 255.
- rst_n pulsed low during EXEC → all outputs go to reset values immediately, with no rsp_valid for the discarded operation. After release a tie grants requester 0 first.

Source files
------------

// File: rtl/ula_scheduler_if.sv
// ula_scheduler_if: request, ULA and response signals of the ULA scheduler.
// master = scheduler side, slave = requesters, ULA and response consumer.
// The scheduler drives the readys, the ULA operands and the tagged response.
interface ula_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_f;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_f;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_f;
  logic [WIDTH-1:0] alu_saida;
  logic             alu_flag_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_saida;
  logic             rsp_flag_o;
  logic             busy;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    input  req0_valid, req0_a, req0_b, req0_f,
    input  req1_valid, req1_a, req1_b, req1_f,
    input  alu_saida, alu_flag_o, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_f,
    output rsp_valid, rsp_id, rsp_saida, rsp_flag_o,
    output busy, ovf_count
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_f,
    output req1_valid, req1_a, req1_b, req1_f,
    output alu_saida, alu_flag_o, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_f,
    input  rsp_valid, rsp_id, rsp_saida, rsp_flag_o,
    input  busy, ovf_count
  );
endinterface

// File: rtl/ula_scheduler.sv
// ula_scheduler: round-robin sequencer sharing one external combinational ULA between two requesters.
// Latency: accept -> rsp_valid 2 cycles; one operation in flight, at least 3 cycles per operation.
// Backpressure: rsp_ready low holds the response stable; both readys stay low until back in IDLE.
module ula_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  ula_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic             w_flag;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_rsp_valid;
  logic             w_busy;
  logic             r_last_grant;
  logic             r_id;
  logic             r_flag;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_f;
  logic [WIDTH-1:0] r_saida;
  logic [CNT_W-1:0] r_ovf_count;

  // Grant selection: a lone requester wins; on a tie the one not served last wins.
  // Only ADD/SUB (f[1]=1) can overflow, so the logic ops mask the ULA flag.
  always_comb begin
    w_gnt0   = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    w_gnt1   = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    w_accept = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);
    w_flag   = bus.alu_flag_o && r_alu_f[1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: IDLE -> EXEC on a grant, EXEC -> RESP always, RESP -> IDLE on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt0 || w_gnt1) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; readys are also held low while reset is asserted.
  always_comb begin
    w_req0_ready = rst_n && (r_state == S_IDLE) && w_gnt0;
    w_req1_ready = rst_n && (r_state == S_IDLE) && w_gnt1;
    w_rsp_valid  = (r_state == S_RESP);
    w_busy       = (r_state != S_IDLE);
  end

  // Register the granted operation; alu_* keep the last issued op until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_f      <= 2'b00;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_alu_a      <= w_gnt1 ? bus.req1_a : bus.req0_a;
      r_alu_b      <= w_gnt1 ? bus.req1_b : bus.req0_b;
      r_alu_f      <= w_gnt1 ? bus.req1_f : bus.req0_f;
      r_id         <= w_gnt1;
      r_last_grant <= w_gnt1;
    end
  end

  // Capture result and flag at the end of EXEC; overflow count saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_saida     <= '0;
      r_flag      <= 1'b0;
      r_ovf_count <= '0;
    end else if (r_state == S_EXEC) begin
      r_saida <= bus.alu_saida;
      r_flag  <= w_flag;
      if (w_flag && (r_ovf_count != {CNT_W{1'b1}})) begin
        r_ovf_count <= r_ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.req0_ready = w_req0_ready;
  assign bus.req1_ready = w_req1_ready;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_f      = r_alu_f;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_saida  = r_saida;
  assign bus.rsp_flag_o = r_flag;
  assign bus.busy       = w_busy;
  assign bus.ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_ula_scheduler.sv
// tb_ula_scheduler: directed stimulus with a response scoreboard for ula_scheduler.
// A behavioural ULA closes the loop; expected responses are queued at issue time.
// A forked monitor pops and compares on every rsp_valid&&rsp_ready.
module tb_ula_scheduler;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic       id;
    logic [7:0] s;
    logic       f;
    logic [7:0] o;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [7:0] w_sum;
  logic [7:0] w_dif;

  always #5 clk = ~clk;

  ula_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ula_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural ULA; logic ops return a junk flag of 1 that the scheduler must mask.
  always_comb begin
    w_sum          = bus.alu_a + bus.alu_b;
    w_dif          = bus.alu_a - bus.alu_b;
    bus.alu_saida  = 8'h00;
    bus.alu_flag_o = 1'b1;
    case (bus.alu_f)
      2'b00: bus.alu_saida = bus.alu_a & bus.alu_b;
      2'b01: bus.alu_saida = bus.alu_a | bus.alu_b;
      2'b10: begin
        bus.alu_saida  = w_sum;
        bus.alu_flag_o = (bus.alu_a[7] == bus.alu_b[7]) && (w_sum[7] != bus.alu_a[7]);
      end
      default: begin
        bus.alu_saida  = w_dif;
        bus.alu_flag_o = (bus.alu_a[7] != bus.alu_b[7]) && (w_dif[7] != bus.alu_a[7]);
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] s, input logic f, input logic [7:0] o);
    exp_t e;
    e.id = id;
    e.s  = s;
    e.f  = f;
    e.o  = o;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got id=%0d saida=0x%0h expected no response",
                   bus.rsp_id, bus.rsp_saida);
        end else begin
          e = sb.pop_front();
          chk("rsp_id",    32'(bus.rsp_id),     32'(e.id));
          chk("rsp_saida", 32'(bus.rsp_saida),  32'(e.s));
          chk("rsp_flag",  32'(bus.rsp_flag_o), 32'(e.f));
          chk("ovf_count", 32'(bus.ovf_count),  32'(e.o));
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(bus.busy), 0);
  endtask

  task automatic set_req0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_f     = f;
  endtask

  task automatic set_req1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_f     = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int acc;
    int cyc;
    int last;
    set_req0(1'b0, 8'h00, 8'h00, 2'b00);
    set_req1(1'b0, 8'h00, 8'h00, 2'b00);
    bus.rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset values, readys gated low even with both requesters valid.
    #1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #5;
    chk("rst_rdy0",  32'(bus.req0_ready), 0);
    chk("rst_rdy1",  32'(bus.req1_ready), 0);
    chk("rst_busy",  32'(bus.busy),       0);
    chk("rst_rspv",  32'(bus.rsp_valid),  0);
    chk("rst_alu_a", 32'(bus.alu_a),      0);
    chk("rst_alu_f", 32'(bus.alu_f),      0);
    chk("rst_id",    32'(bus.rsp_id),     0);
    chk("rst_saida", 32'(bus.rsp_saida),  0);
    chk("rst_flag",  32'(bus.rsp_flag_o), 0);
    chk("rst_ovf",   32'(bus.ovf_count),  0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Requester 0 alone: 100+50 overflows to 0x96.
    @(posedge clk); #1;
    set_req0(1'b1, 8'd100, 8'd50, 2'b10);
    push(1'b0, 8'h96, 1'b1, 8'd1);
    @(negedge clk);
    chk("t1_rdy0", 32'(bus.req0_ready), 1);
    chk("t1_rdy1", 32'(bus.req1_ready), 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_exec_busy", 32'(bus.busy),      1);
    chk("t1_exec_rspv", 32'(bus.rsp_valid), 0);
    chk("t1_alu_a",     32'(bus.alu_a),     100);
    chk("t1_alu_b",     32'(bus.alu_b),     50);
    chk("t1_alu_f",     32'(bus.alu_f),     2);
    @(negedge clk);
    chk("t1_rspv_lat",  32'(bus.rsp_valid), 1);
    chk("t1_ovf_vis",   32'(bus.ovf_count), 1);
    wait_idle("t1");

    // Tie from reset: requester 0 first, requester 1 waits for the full first operation.
    do_reset();
    @(posedge clk); #1;
    set_req0(1'b1, 8'd5, 8'd3, 2'b11);
    set_req1(1'b1, 8'hF0, 8'h3C, 2'b00);
    push(1'b0, 8'h02, 1'b0, 8'd0);
    push(1'b1, 8'h30, 1'b0, 8'd0);
    @(negedge clk);
    chk("t2_rdy0", 32'(bus.req0_ready), 1);
    chk("t2_rdy1", 32'(bus.req1_ready), 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus.req1_ready) break;
    end
    chk("t2_rdy1_wait", 32'(n), 3);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_idle("t2");

    // Backpressure: response held 5 cycles while requester 1 waits.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req0(1'b1, 8'd10, 8'd20, 2'b10);
    push(1'b0, 8'd30, 1'b0, 8'd0);
    @(negedge clk);
    chk("t3_rdy0", 32'(bus.req0_ready), 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    set_req1(1'b1, 8'd1, 8'd2, 2'b10);
    push(1'b1, 8'd3, 1'b0, 8'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_rspv",  32'(bus.rsp_valid),  1);
      chk("t3_hold_id",    32'(bus.rsp_id),     0);
      chk("t3_hold_saida", 32'(bus.rsp_saida),  30);
      chk("t3_hold_flag",  32'(bus.rsp_flag_o), 0);
      chk("t3_hold_rdy0",  32'(bus.req0_ready), 0);
      chk("t3_hold_rdy1",  32'(bus.req1_ready), 0);
      chk("t3_hold_busy",  32'(bus.busy),       1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_rdy1", 32'(bus.req1_ready), 0);
    @(negedge clk);
    chk("t3_post_busy", 32'(bus.busy),       0);
    chk("t3_post_rdy1", 32'(bus.req1_ready), 1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_idle("t3");

    // Fairness: last grant was requester 1, so ids run 0,1,0,1,0,1 every 3 cycles.
    @(posedge clk); #1;
    set_req0(1'b1, 8'd1, 8'd1, 2'b10);
    set_req1(1'b1, 8'd3, 8'd4, 2'b10);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 8'd2, 1'b0, 8'd0);
      push(1'b1, 8'd7, 1'b0, 8'd0);
    end
    acc = 0;
    cyc = 0;
    last = 0;
    while (acc < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.req0_ready || bus.req1_ready) begin
        chk("t4_onehot", 32'(bus.req0_ready & bus.req1_ready), 0);
        if (acc > 0) chk("t4_spacing", 32'(cyc - last), 3);
        last = cyc;
        acc++;
        if (acc == 6) begin
          @(posedge clk); #1;
          bus.req0_valid = 1'b0;
          bus.req1_valid = 1'b0;
        end
      end
    end
    chk("t4_accepts", 32'(acc), 6);
    wait_idle("t4");

    // Saturation: 260 overflowing adds, counter stops at 255.
    @(posedge clk); #1;
    set_req0(1'b1, 8'd127, 8'd1, 2'b10);
    for (int i = 0; i < 260; i++) begin
      push(1'b0, 8'h80, 1'b1, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
    end
    acc = 0;
    cyc = 0;
    while (acc < 260 && cyc < 900) begin
      @(negedge clk);
      cyc++;
      if (bus.req0_ready) begin
        acc++;
        if (acc == 260) begin
          @(posedge clk); #1;
          bus.req0_valid = 1'b0;
        end
      end
    end
    chk("t5_accepts", 32'(acc), 260);
    wait_idle("t5");
    chk("t5_ovf_sat", 32'(bus.ovf_count), 255);

    // Reset mid-EXEC: operation dropped, outputs cleared at once, then a tie goes to requester 0.
    @(posedge clk); #1;
    set_req0(1'b1, 8'd100, 8'd50, 2'b10);
    @(posedge clk); #1;
    set_req0(1'b1, 8'd7, 8'd1, 2'b10);
    set_req1(1'b1, 8'd9, 8'd9, 2'b01);
    #2;
    chk("t6_pre_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(bus.busy),       0);
    chk("t6_rst_rspv",  32'(bus.rsp_valid),  0);
    chk("t6_rst_rdy0",  32'(bus.req0_ready), 0);
    chk("t6_rst_rdy1",  32'(bus.req1_ready), 0);
    chk("t6_rst_alu_a", 32'(bus.alu_a),      0);
    chk("t6_rst_saida", 32'(bus.rsp_saida),  0);
    chk("t6_rst_flag",  32'(bus.rsp_flag_o), 0);
    chk("t6_rst_ovf",   32'(bus.ovf_count),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(1'b0, 8'd8, 1'b0, 8'd0);
    push(1'b1, 8'd9, 1'b0, 8'd0);
    @(negedge clk);
    chk("t6_rdy0", 32'(bus.req0_ready), 1);
    chk("t6_rdy1", 32'(bus.req1_ready), 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus.req1_ready) break;
    end
    chk("t6_rdy1_wait", 32'(n), 3);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_idle("t6");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
